// File: rtl/imuldiv_div_arbiter_pkg.sv
// Shared constants and message types for the two-requester divider arbiter.
package imuldiv_div_arbiter_pkg;

  localparam int unsigned OP_W  = 32;
  localparam int unsigned RES_W = 64;

  // Function encoding reused from the divreq message header
  localparam logic DIVREQ_FN_SIGNED   = 1'b0;
  localparam logic DIVREQ_FN_UNSIGNED = 1'b1;

  localparam logic [OP_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_LOCAL = 2'd3;

  typedef struct packed {
    logic            fn;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } divreq_msg_t;

endpackage

// File: rtl/imuldiv_div_arbiter_if.sv
// Handshake bundle between the arbiter, its two requesters and the divider.
interface imuldiv_div_arbiter_if;
  import imuldiv_div_arbiter_pkg::*;

  logic             req0_val;
  logic             req0_rdy;
  logic             req0_msg_fn;
  logic [OP_W-1:0]  req0_msg_a;
  logic [OP_W-1:0]  req0_msg_b;
  logic             req1_val;
  logic             req1_rdy;
  logic             req1_msg_fn;
  logic [OP_W-1:0]  req1_msg_a;
  logic [OP_W-1:0]  req1_msg_b;

  logic             resp0_val;
  logic             resp0_rdy;
  logic [RES_W-1:0] resp0_msg_result;
  logic             resp1_val;
  logic             resp1_rdy;
  logic [RES_W-1:0] resp1_msg_result;

  logic             divreq_val;
  logic             divreq_rdy;
  logic             divreq_msg_fn;
  logic [OP_W-1:0]  divreq_msg_a;
  logic [OP_W-1:0]  divreq_msg_b;
  logic             divresp_val;
  logic             divresp_rdy;
  logic [RES_W-1:0] divresp_msg_result;

  // Arbiter side
  modport slave (
    input  req0_val, req0_msg_fn, req0_msg_a, req0_msg_b,
    input  req1_val, req1_msg_fn, req1_msg_a, req1_msg_b,
    output req0_rdy, req1_rdy,
    output resp0_val, resp0_msg_result, resp1_val, resp1_msg_result,
    input  resp0_rdy, resp1_rdy,
    output divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
    input  divreq_rdy,
    input  divresp_val, divresp_msg_result,
    output divresp_rdy
  );

  // Requester / divider side
  modport master (
    output req0_val, req0_msg_fn, req0_msg_a, req0_msg_b,
    output req1_val, req1_msg_fn, req1_msg_a, req1_msg_b,
    input  req0_rdy, req1_rdy,
    input  resp0_val, resp0_msg_result, resp1_val, resp1_msg_result,
    output resp0_rdy, resp1_rdy,
    input  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
    output divreq_rdy,
    output divresp_val, divresp_msg_result,
    input  divresp_rdy
  );

endinterface

// File: rtl/imuldiv_div_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant: the pri requester wins when valid.
module imuldiv_rr_arb2 (
  input  logic i_val0,
  input  logic i_val1,
  input  logic i_pri,
  output logic o_gnt_val,
  output logic o_gnt
);

  always_comb begin
    o_gnt_val = i_val0 | i_val1;
    if (i_pri) o_gnt = i_val1 ? 1'b1 : 1'b0;
    else       o_gnt = i_val0 ? 1'b0 : 1'b1;
  end

endmodule

// File: rtl/imuldiv_div_arbiter.sv
// Shares one iterative divider between two requesters, one operation in flight.
// Optional IMULDIV_DIV_ARB_DIV0_BYPASS_EN answers divide-by-zero locally.
module imuldiv_div_arbiter
  import imuldiv_div_arbiter_pkg::*;
#(
  parameter int   NREQ     = 2,
  parameter logic INIT_PRI = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  imuldiv_div_arbiter_if.slave  bus
);

  localparam int unsigned OWN_W = $clog2(NREQ);

  logic [1:0]       r_state;
  logic [OWN_W-1:0] r_owner;
  logic             r_pri;
  divreq_msg_t      r_buf;

  logic             w_gnt_val;
  logic             w_gnt;
  logic             w_idle;
  divreq_msg_t      w_sel_msg;
  logic             w_own_rdy;
  logic             w_rsp_val;
  logic [RES_W-1:0] w_rsp_result;
  logic             w_done;

  imuldiv_rr_arb2 u_arb (
    .i_val0    (bus.req0_val),
    .i_val1    (bus.req1_val),
    .i_pri     (r_pri),
    .o_gnt_val (w_gnt_val),
    .o_gnt     (w_gnt)
  );

  assign w_idle       = (r_state == ST_IDLE);
  assign bus.req0_rdy = w_idle && w_gnt_val && !w_gnt && bus.req0_val;
  assign bus.req1_rdy = w_idle && w_gnt_val &&  w_gnt && bus.req1_val;

  assign w_sel_msg = w_gnt ? '{fn: bus.req1_msg_fn, a: bus.req1_msg_a, b: bus.req1_msg_b}
                           : '{fn: bus.req0_msg_fn, a: bus.req0_msg_a, b: bus.req0_msg_b};

  assign w_own_rdy = r_owner[0] ? bus.resp1_rdy : bus.resp0_rdy;

  assign bus.divreq_val    = (r_state == ST_ISSUE);
  assign bus.divreq_msg_fn = r_buf.fn;
  assign bus.divreq_msg_a  = r_buf.a;
  assign bus.divreq_msg_b  = r_buf.b;
  assign bus.divresp_rdy   = (r_state == ST_WAIT) && w_own_rdy;

  always_comb begin
    w_rsp_val    = 1'b0;
    w_rsp_result = '0;
    case (r_state)
      ST_WAIT: begin
        w_rsp_val    = bus.divresp_val;
        w_rsp_result = bus.divresp_msg_result;
      end
`ifdef IMULDIV_DIV_ARB_DIV0_BYPASS_EN
      ST_LOCAL: begin
        w_rsp_val    = 1'b1;
        w_rsp_result = {r_buf.a, DIV0_QUOT};
      end
`endif
      default: ;
    endcase
  end

  // Both requesters see the result bus; only the owner sees valid
  assign bus.resp0_val        = w_rsp_val && !r_owner[0];
  assign bus.resp1_val        = w_rsp_val &&  r_owner[0];
  assign bus.resp0_msg_result = w_rsp_result;
  assign bus.resp1_msg_result = w_rsp_result;

  assign w_done = w_rsp_val && w_own_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_pri   <= INIT_PRI;
      r_buf   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_val) begin
            r_buf      <= w_sel_msg;
            r_owner[0] <= w_gnt;
`ifdef IMULDIV_DIV_ARB_DIV0_BYPASS_EN
            r_state    <= (w_sel_msg.b == '0) ? ST_LOCAL : ST_ISSUE;
`else
            r_state    <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          if (bus.divreq_rdy) r_state <= ST_WAIT;
        end
        ST_WAIT, ST_LOCAL: begin
          if (w_done) begin
            r_pri   <= ~r_owner[0];
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Directed bench for imuldiv_div_arbiter; the bench plays both requesters and the divider.
module tb_imuldiv_div_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  imuldiv_div_arbiter_if bus ();

  imuldiv_div_arbiter #(.NREQ(2), .INIT_PRI(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          req;
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit r, input logic v, input logic fn,
                         input logic [31:0] a, input logic [31:0] b);
    if (r) begin
      bus.req1_val = v; bus.req1_msg_fn = fn; bus.req1_msg_a = a; bus.req1_msg_b = b;
    end else begin
      bus.req0_val = v; bus.req0_msg_fn = fn; bus.req0_msg_a = a; bus.req0_msg_b = b;
    end
  endtask

  function automatic logic req_rdy(input bit r);
    return r ? bus.req1_rdy : bus.req0_rdy;
  endfunction

  function automatic logic resp_val(input bit r);
    return r ? bus.resp1_val : bus.resp0_val;
  endfunction

  function automatic logic [63:0] resp_res(input bit r);
    return r ? bus.resp1_msg_result : bus.resp0_msg_result;
  endfunction

  task automatic set_resp_rdy(input bit r, input logic v);
    if (r) bus.resp1_rdy = v;
    else   bus.resp0_rdy = v;
  endtask

  task automatic clear_inputs();
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    bus.resp0_rdy = 1'b0;
    bus.resp1_rdy = 1'b0;
    bus.divreq_rdy = 1'b0;
    bus.divresp_val = 1'b0;
    bus.divresp_msg_result = '0;
  endtask

  // In ISSUE: check the buffered request, then let the divider take it
  task automatic do_issue(input logic fn, input logic [31:0] a, input logic [31:0] b);
    chk("divreq_val in ISSUE", {63'd0, bus.divreq_val}, 64'd1);
    chk("divreq_msg_a", {32'd0, bus.divreq_msg_a}, {32'd0, a});
    chk("divreq_msg_b", {32'd0, bus.divreq_msg_b}, {32'd0, b});
    chk("divreq_msg_fn", {63'd0, bus.divreq_msg_fn}, {63'd0, fn});
    bus.divreq_rdy = 1'b1;
    tick();
    bus.divreq_rdy = 1'b0;
    chk("divreq_val in WAIT", {63'd0, bus.divreq_val}, 64'd0);
  endtask

  // In WAIT: divider returns res, owner takes it in the same cycle
  task automatic do_resp(input bit own, input logic [63:0] res);
    bus.divresp_val = 1'b1;
    bus.divresp_msg_result = res;
    set_resp_rdy(own, 1'b1);
    #1;
    chk("owner resp_val", {63'd0, resp_val(own)}, 64'd1);
    chk("non-owner resp_val", {63'd0, resp_val(!own)}, 64'd0);
    chk("resp result", resp_res(own), res);
    chk("divresp_rdy", {63'd0, bus.divresp_rdy}, 64'd1);
    tick();
    bus.divresp_val = 1'b0;
    bus.divresp_msg_result = '0;
    set_resp_rdy(own, 1'b0);
    #1;
    chk("divresp_rdy after fire", {63'd0, bus.divresp_rdy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    set_req(v.req, 1'b1, v.fn, v.a, v.b);
    #1;
    chk("granted rdy", {63'd0, req_rdy(v.req)}, 64'd1);
    chk("idle other rdy", {63'd0, req_rdy(!v.req)}, 64'd0);
    tick();
    set_req(v.req, 1'b0, 1'b0, '0, '0);
    #1;
`ifdef IMULDIV_DIV_ARB_DIV0_BYPASS_EN
    if (v.b == 32'd0) begin
      chk("div0 no divreq", {63'd0, bus.divreq_val}, 64'd0);
      chk("div0 resp_val", {63'd0, resp_val(v.req)}, 64'd1);
      chk("div0 result", resp_res(v.req), {v.a, 32'hFFFF_FFFF});
      set_resp_rdy(v.req, 1'b1);
      tick();
      set_resp_rdy(v.req, 1'b0);
      #1;
      chk("div0 resp_val after", {63'd0, resp_val(v.req)}, 64'd0);
    end else
`endif
    begin
      do_issue(v.fn, v.a, v.b);
      chk("resp_val before divresp", {63'd0, resp_val(v.req)}, 64'd0);
      do_resp(v.req, v.res);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // fn=1 unsigned, fn=0 signed; results are {rem, quot}
    vecs[0] = '{req: 1'b0, fn: 1'b1, a: 32'd100,        b: 32'd7,  res: 64'h00000002_0000000E};
    vecs[1] = '{req: 1'b1, fn: 1'b1, a: 32'hFFFF_FFFF,  b: 32'd16, res: 64'h0000000F_0FFFFFFF};
    vecs[2] = '{req: 1'b0, fn: 1'b0, a: 32'hFFFF_FFF9,  b: 32'd2,  res: 64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{req: 1'b1, fn: 1'b1, a: 32'h0000_1234,  b: 32'd0,  res: 64'h00001234_FFFFFFFF};

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset divreq_val", {63'd0, bus.divreq_val}, 64'd0);
    chk("reset divresp_rdy", {63'd0, bus.divresp_rdy}, 64'd0);
    chk("reset resp0_val", {63'd0, bus.resp0_val}, 64'd0);
    chk("reset resp1_val", {63'd0, bus.resp1_val}, 64'd0);
    chk("reset divreq_msg_a", {32'd0, bus.divreq_msg_a}, 64'd0);
    chk("reset resp0_result", bus.resp0_msg_result, 64'd0);

    // Contention from reset (pri=0): req0 first, req1 next, bubble between
    set_req(1'b0, 1'b1, 1'b1, 32'd50, 32'd5);
    set_req(1'b1, 1'b1, 1'b1, 32'd9,  32'd4);
    #1;
    chk("contend rdy0", {63'd0, bus.req0_rdy}, 64'd1);
    chk("contend rdy1", {63'd0, bus.req1_rdy}, 64'd0);
    tick();
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rdy1 in ISSUE", {63'd0, bus.req1_rdy}, 64'd0);
    do_issue(1'b1, 32'd50, 32'd5);
    chk("rdy1 in WAIT", {63'd0, bus.req1_rdy}, 64'd0);
    bus.divresp_val = 1'b1;
    bus.divresp_msg_result = 64'h00000000_0000000A;
    bus.resp0_rdy = 1'b1;
    #1;
    chk("contend resp0_val", {63'd0, bus.resp0_val}, 64'd1);
    chk("contend resp1_val", {63'd0, bus.resp1_val}, 64'd0);
    chk("no same-cycle turnaround", {63'd0, bus.req1_rdy}, 64'd0);
    tick();
    bus.divresp_val = 1'b0;
    bus.resp0_rdy = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 32'd60, 32'd6);
    #1;
    chk("fair rdy1", {63'd0, bus.req1_rdy}, 64'd1);
    chk("fair rdy0", {63'd0, bus.req0_rdy}, 64'd0);
    tick();
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    do_issue(1'b1, 32'd9, 32'd4);
    chk("rdy0 while req1 served", {63'd0, bus.req0_rdy}, 64'd0);
    do_resp(1'b1, 64'h00000001_00000002);
    set_req(1'b1, 1'b1, 1'b1, 32'd8, 32'd2);
    #1;
    chk("pri back to 0 rdy0", {63'd0, bus.req0_rdy}, 64'd1);
    chk("pri back to 0 rdy1", {63'd0, bus.req1_rdy}, 64'd0);
    tick();
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    do_issue(1'b1, 32'd60, 32'd6);
    do_resp(1'b0, 64'h00000000_0000000A);
    chk("pri now 1 rdy1", {63'd0, bus.req1_rdy}, 64'd1);
    chk("pri now 1 rdy0", {63'd0, bus.req0_rdy}, 64'd0);
    // req1 withdraws before the edge: nothing fires, pri stays 1
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    chk("withdrawn divreq_val", {63'd0, bus.divreq_val}, 64'd0);

    for (int unsigned i = 0; i < 4; i++) run_vec(vecs[i]);

    // Backpressure on both divider request and owner response
    set_req(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd3);
    tick();
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      chk("bp divreq_val held", {63'd0, bus.divreq_val}, 64'd1);
      chk("bp divreq_a stable", {32'd0, bus.divreq_msg_a}, 64'h80000000);
      tick();
    end
    do_issue(1'b0, 32'h8000_0000, 32'd3);
    bus.divresp_val = 1'b1;
    bus.divresp_msg_result = 64'hFFFFFFFE_D5555556;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("bp resp0_val held", {63'd0, bus.resp0_val}, 64'd1);
      chk("bp divresp_rdy low", {63'd0, bus.divresp_rdy}, 64'd0);
      chk("bp result held", bus.resp0_msg_result, 64'hFFFFFFFE_D5555556);
      tick();
    end
    do_resp(1'b0, 64'hFFFFFFFE_D5555556);

    // Reset while waiting for the divider
    set_req(1'b1, 1'b1, 1'b1, 32'd20, 32'd3);
    tick();
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    do_issue(1'b1, 32'd20, 32'd3);
    bus.divresp_val = 1'b1;
    bus.divresp_msg_result = 64'h00000002_00000006;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("post-reset resp1_val", {63'd0, bus.resp1_val}, 64'd0);
    chk("post-reset resp0_val", {63'd0, bus.resp0_val}, 64'd0);
    chk("post-reset divreq_val", {63'd0, bus.divreq_val}, 64'd0);
    chk("post-reset divresp_rdy", {63'd0, bus.divresp_rdy}, 64'd0);
    bus.divresp_val = 1'b0;
    bus.divresp_msg_result = '0;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imuldiv_div_arbiter.md
Name: imuldiv_div_arbiter

Overview:
- Round-robin arbiter that shares one iterative divider between two requesters, e.g. the integer pipeline and a second execute port.
- Accepts one request at a time, buffers it and issues it to the divider.
- Routes the divider's 64-bit {remainder, quotient} response back to the requester that owns it.
- Only one operation is outstanding at any time, because the divider is iterative and non-pipelined.

Parameters:
- NREQ, 2, number of requesters; fixed at 2, and other values are unsupported.
- INIT_PRI, 0, requester favoured after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_val  in  1  requester 0 request valid
- req0_rdy  out  1  requester 0 request accepted
- req0_msg_fn  in  1  requester 0 function (divreq fn encoding)
- req0_msg_a  in  32  requester 0 dividend
- req0_msg_b  in  32  requester 0 divisor
- req1_val, req1_rdy, req1_msg_fn, req1_msg_a, req1_msg_b: same as requester 0, for requester 1
- resp0_val  out  1  response valid to requester 0
- resp0_rdy  in  1  requester 0 can take the response
- resp0_msg_result  out  64  {rem[31:0], quot[31:0]}
- resp1_val, resp1_rdy, resp1_msg_result: same as requester 0, for requester 1
- divreq_val  out  1  request valid to the divider
- divreq_rdy  in  1  divider accepts the request
- divreq_msg_fn  out  1  buffered function
- divreq_msg_a  out  32  buffered dividend
- divreq_msg_b  out  32  buffered divisor
- divresp_val  in  1  divider result valid
- divresp_rdy  out  1  arbiter accepts the result
- divresp_msg_result  in  64  divider result

Behaviour:
- **States:** IDLE, ISSUE, WAIT; plus LOCAL when the optional feature is compiled in. State is held in a registered 2-bit encoding.
- **Registers:** fn/a/b buffer (65 bits), owner (1 bit), pri pointer (1 bit).

Reset (synchronous):
- state=IDLE, owner=0, pri=INIT_PRI, buffer=0.
- All outputs are 0 in the cycle after reset, except req*_rdy, which follows IDLE grant logic.
- Reset mid-operation abandons the transaction with no response. The divider is reset by the same signal.

Grant (IDLE only):
- grant = req_pri_val ? pri : other when req_other_val; otherwise no grant.
- reqX_rdy = (state==IDLE) && (grant==X) && reqX_val.
- The non-granted requester sees rdy=0.

IDLE:
- On fire of reqX, latch msg into the buffer, set owner=X, go to ISSUE.
- When both requesters are valid, only the pri requester fires.

ISSUE:
- divreq_val=1 and divreq_msg_* = buffer.
- On divreq_rdy: go to WAIT.
- divreq_val is held, with stable data, until accepted.

WAIT:
- respX_val = divresp_val && (owner==X).
- Both respX_msg_result = divresp_msg_result.
- divresp_rdy = resp_owner_rdy.
- On response fire: pri = ~owner, go to IDLE.
- A new request is accepted no earlier than the cycle after the response fire. This gives a bubble cycle; no same-cycle turnaround.

Other rules:
- The non-owner resp_val is always 0.
- resp*_val=0 outside WAIT and LOCAL.
- divreq_val=0 outside ISSUE.
- divresp_rdy=0 outside WAIT.
- Arbiter latency: request fire cycle N gives divreq_val at N+1. The response is forwarded combinationally in the same cycle as divresp_val.
- A requester that deasserts val before grant loses nothing. pri changes only on completion.
- A requester that waits indefinitely is guaranteed service within one foreign transaction (round-robin fairness).

Optional Feature:
- Macro: IMULDIV_DIV_ARB_DIV0_BYPASS_EN.
- Defined: in IDLE, an accepted request with b==0 goes to LOCAL instead of ISSUE. The divider is not touched.
  - LOCAL drives respX_val=1 for the owner, with result {a, 32'hFFFFFFFF} regardless of fn.
  - On respX_rdy: update pri, go to IDLE.
- Not defined: LOCAL does not exist. Divide-by-zero goes to the divider, and its result is passed through unchanged.

Decomposition:
- Shared package/header (imuldiv-DivArbMsg.v):
  - state encoding localparams;
  - result width 64, operand width 32;
  - divide-by-zero quotient constant 32'hFFFFFFFF.
- The fn encoding is reused from the existing divreq message header.
- Sub-module: imuldiv_rr_arb2, a combinational 2-way grant from {val0, val1, pri}. It is instantiated once and is independently testable.

Test Plan:
- Single request: req0 fn=unsigned, a=100, b=7, divider returns 64'h00000002_0000000E → resp0_val with that result, resp1_val=0; divreq at N+1, then back to IDLE.
- Contention: req0 and req1 both valid at reset (pri=0) → req0 granted first; req1 granted in the first IDLE after resp0 fire; pri toggles each completion.
- Backpressure: hold divreq_rdy=0 for 5 cycles → divreq_val stays 1 with stable a/b. Then hold resp0_rdy=0 for 3 cycles → divresp_rdy=0 and result is held; no state advance.
- Fairness: req0 continuously valid with back-to-back ops, req1 raised mid-op → req1 served next. req0 is never served twice in a row while req1 is pending.
- Reset mid-op: assert reset in WAIT → next cycle state=IDLE, all val outputs 0, no stale response; the next request completes normally.
- DIV0 (macro on): req1 a=32'h1234, b=0 → no divreq_val; resp1 = 64'h00001234_FFFFFFFF within 1 cycle of acceptance. With the macro off, the same stimulus reaches the divider.
